ex_stage_pipe: RTL

Parametrised, pipelined execute stage for the LEGv8 datapath. It is the successor to the single-cycle execute logic. It adds operand forwarding, a registered EX/MEM output with a valid/ready handshake, a persistent NZVC flags register for conditional branches, and an optional iterative multiplier. It sits between the ID/EX register and the memory stage, and computes the ALU result, the store data, the branch target and the branch decision.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/seq_multiplier.sv | 45 ++++
 rtl/ex_stage_pipe.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the LEGv8 execute stage
package cpu_pkg;
    typedef enum logic [2:0] {
        ALU_PASS_B     = 3'b000,
        ALU_PASS_B_ALT = 3'b001,
        ALU_ADD        = 3'b010,
        ALU_SUB        = 3'b011,
        ALU_AND        = 3'b100,
        ALU_OR         = 3'b101,
        ALU_XOR        = 3'b110,
        ALU_MUL        = 3'b111
    } alu_op_t;
    typedef enum logic [1:0] {BR_NONE, BR_UNCOND, BR_CBZ, BR_LT} br_mode_t;
    typedef enum logic [1:0] {FWD_RF, FWD_MEM, FWD_WB, FWD_RF_ALT} fwd_sel_t;
    typedef enum logic {EX_IDLE, EX_MUL} ex_state_t;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;
endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier, one multiplier bit per cycle.
// done is high during the last iteration; product then holds the final low WIDTH bits.
module seq_multiplier #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [CW-1:0] cnt;
    logic busy;
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done = busy && cnt == CW'(WIDTH - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            cnt <= '0;
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt <= '0;
            acc <= '0;
            mcand <= a;
            mplier <= b;
        end else if (busy) begin
            acc <= product;
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            cnt <= cnt + CW'(1);
            busy <= !done;
        end
    end
endmodule

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: pipelined LEGv8 execute stage with forwarding, registered EX/MEM
// output under valid/ready, persistent NZVC flags and an optional iterative multiplier.
module ex_stage_pipe
    import cpu_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int BR_SHIFT = 2,
    parameter bit MUL_EN   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] read_data1,
    input  logic [WIDTH-1:0] read_data2,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] br_offset,
    input  logic [2:0]       alu_op,
    input  logic             alu_src,
    input  logic             set_flags,
    input  logic [1:0]       br_mode,
    input  logic [1:0]       fwd_a_sel,
    input  logic [1:0]       fwd_b_sel,
    input  logic [WIDTH-1:0] mem_fwd,
    input  logic [WIDTH-1:0] wb_fwd,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] store_data,
    output logic [WIDTH-1:0] br_target,
    output logic             branch_taken,
    output logic [3:0]       flags
);
    ex_state_t state, state_next;
    logic [WIDTH-1:0] op_a, op_b_fwd, op_b, alu_res, prod, target;
    logic [WIDTH-1:0] held_store, held_target;
    logic [WIDTH:0] add_full, sub_full;
    logic [3:0] res_flags;
    logic cout, ovf, is_mul, accept, load_alu, load_mul, mul_done, taken, held_taken;

    assign op_a = fwd_a_sel == FWD_MEM ? mem_fwd : fwd_a_sel == FWD_WB ? wb_fwd : read_data1;
    assign op_b_fwd = fwd_b_sel == FWD_MEM ? mem_fwd : fwd_b_sel == FWD_WB ? wb_fwd : read_data2;
    assign op_b = alu_src ? imm : op_b_fwd;
    assign target = pc + (br_offset << BR_SHIFT);
    assign is_mul = MUL_EN && alu_op == ALU_MUL;
    // B.LT reads the flags register as it stood before this instruction.
    assign taken = br_mode == BR_UNCOND ? 1'b1 :
                   br_mode == BR_CBZ    ? op_b_fwd == '0 :
                   br_mode == BR_LT     ? flags[FLAG_N] ^ flags[FLAG_V] : 1'b0;

    assign in_ready = !reset && state == EX_IDLE && (!out_valid || out_ready) && !flush;
    assign accept = in_valid && in_ready;
    assign load_alu = accept && !is_mul;
    assign load_mul = state == EX_MUL && mul_done && !flush;

    assign add_full = {1'b0, op_a} + {1'b0, op_b};
    assign sub_full = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        alu_res = op_b;
        cout = 1'b0;
        ovf = 1'b0;
        case (alu_op_t'(alu_op))
            ALU_ADD: begin
                alu_res = add_full[WIDTH-1:0];
                cout = add_full[WIDTH];
                ovf = op_a[WIDTH-1] == op_b[WIDTH-1] && alu_res[WIDTH-1] != op_a[WIDTH-1];
            end
            ALU_SUB: begin
                alu_res = sub_full[WIDTH-1:0];
                cout = !sub_full[WIDTH];
                ovf = op_a[WIDTH-1] != op_b[WIDTH-1] && alu_res[WIDTH-1] != op_a[WIDTH-1];
            end
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_XOR: alu_res = op_a ^ op_b;
            default: alu_res = op_b;
        endcase
    end

    always_comb begin
        res_flags = '0;
        res_flags[FLAG_N] = alu_res[WIDTH-1];
        res_flags[FLAG_Z] = alu_res == '0;
        res_flags[FLAG_V] = ovf;
        res_flags[FLAG_C] = cout;
    end

    always_comb begin
        state_next = state;
        if (flush)
            state_next = EX_IDLE;
        else if (state == EX_IDLE && accept && is_mul)
            state_next = EX_MUL;
        else if (state == EX_MUL && mul_done)
            state_next = EX_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= EX_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            alu_result <= '0;
            store_data <= '0;
            br_target <= '0;
            branch_taken <= 1'b0;
            flags <= '0;
            held_store <= '0;
            held_target <= '0;
            held_taken <= 1'b0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (load_alu) begin
                out_valid <= 1'b1;
                alu_result <= alu_res;
                store_data <= op_b_fwd;
                br_target <= target;
                branch_taken <= taken;
            end else if (load_mul) begin
                out_valid <= 1'b1;
                alu_result <= prod;
                store_data <= held_store;
                br_target <= held_target;
                branch_taken <= held_taken;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (load_alu && set_flags)
                flags <= res_flags;
            // Side results of a multiply are captured at accept and released on completion.
            if (accept && is_mul) begin
                held_store <= op_b_fwd;
                held_target <= target;
                held_taken <= taken;
            end
        end
    end

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk(clk),
        .reset(reset),
        .start(accept && is_mul),
        .abort(flush),
        .a(op_a),
        .b(op_b),
        .done(mul_done),
        .product(prod)
    );
endmodule
